// File: rtl/processor_pkg.sv
// Shared encodings for the processor: RV32I major opcodes, funct3 codes,
// fixed instruction words and the control FSM state type.
package processor_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU funct3 codes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Fixed instruction words
  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/processor_regfile.sv
// 31 x 32-bit register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear. x0 is not stored and always reads zero.
module processor_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] x1
);

  logic [31:0] regs [1:31];

  // Write port; reset clears every register so an aborted instruction leaves nothing behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
  assign x1     = regs[1];

endmodule

// File: rtl/processor.sv
// Two-cycle multicycle RV32I core (no loads/stores) with an internal
// word-addressed instruction memory MEM that is preloaded hierarchically.
module processor
  import processor_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  output logic [31:0] x1
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] MEM [0:MEM_WORDS-1];

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] i_imm, b_imm, u_imm, j_imm;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign alt    = ir[30];

  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'b0};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4, next_pc, wb_data;
  logic        wb_en, halt_req, rf_we;

  // ALU shared by OP and OP-IMM; alt selects SUB / SRA
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sel_alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [4:0]         sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (f3)
      F3_ADD:  alu = sel_alt ? (a - b) : (a + b);
      F3_SLL:  alu = a << sh;
      F3_SLT:  alu = {31'd0, (sa < sb)};
      F3_SLTU: alu = {31'd0, (a < b)};
      F3_XOR:  alu = a ^ b;
      F3_SR:   alu = sel_alt ? $unsigned(sa >>> sh) : (a >> sh);
      F3_OR:   alu = a | b;
      F3_AND:  alu = a & b;
      default: alu = '0;
    endcase
  endfunction

  // Branch condition; the two reserved funct3 codes never branch
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      F3_BEQ:  br_taken = (a == b);
      F3_BNE:  br_taken = (a != b);
      F3_BLT:  br_taken = (sa < sb);
      F3_BGE:  br_taken = (sa >= sb);
      F3_BLTU: br_taken = (a < b);
      F3_BGEU: br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  // Decode and execute the latched instruction: writeback value and next PC
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    wb_en    = 1'b0;
    wb_data  = '0;
    halt_req = 1'b0;
    case (opcode)
      OPC_OP: begin
        wb_en   = 1'b1;
        wb_data = alu(funct3, alt, rs1_val, rs2_val);
      end
      OPC_OP_IMM: begin
        // Only shifts use bit 30 as a selector; for ADDI etc. it is immediate data
        wb_en   = 1'b1;
        wb_data = alu(funct3, (funct3 == F3_SR) && alt, rs1_val, i_imm);
      end
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = u_imm;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + u_imm;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + j_imm;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = (rs1_val + i_imm) & ~32'd1;
      end
      OPC_BRANCH: begin
        if (br_taken(funct3, rs1_val, rs2_val)) begin
          next_pc = pc + b_imm;
        end
      end
      OPC_SYSTEM: begin
        // EBREAK parks the PC on itself; ECALL and the rest fall through as NOPs
        if (ir == INSN_EBREAK) begin
          halt_req = 1'b1;
          next_pc  = pc;
        end
      end
      default: ;
    endcase
  end

  assign rf_we = (state == ST_EXECUTE) && wb_en;

  processor_regfile u_regfile (
    .clk    (CLK),
    .rst_n  (reset),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .x1     (x1)
  );

  // Control FSM: FETCH latches the instruction, EXECUTE commits PC, HALT freezes
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= INSN_NOP;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= MEM[pc[AW+1:2]];
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          pc    <= next_pc;
          state <= halt_req ? ST_HALT : ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: table of short programs with hand-computed
// x1 results, plus hand-written sequences for reset, looping and halt.
module tb_processor;
  import processor_pkg::*;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] x1;

  int checks = 0;
  int errors = 0;

  processor #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .CLK   (CLK),
    .reset (reset),
    .x1    (x1)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0]  X0 = 5'd0, X1 = 5'd1, X2 = 5'd2, X3 = 5'd3;
  localparam logic [6:0]  OP = 7'b0110011, OPI = 7'b0010011;

  typedef struct {
    string       name;
    logic [31:0] i0, i1, i2, i3;
    int          cyc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] s2,
                                      input logic [4:0] s1, input logic [2:0] f3,
                                      input logic [4:0] d);
    return {f7, s2, s1, f3, d, OP};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d,
                                      input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] d, input logic [11:0] imm);
    return {imm, X0, 3'b000, d, OPI};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] s2,
                                      input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] d,
                                      input logic [6:0] op);
    return {imm, d, op};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Hold reset, load a program over a NOP-filled memory, release on a falling edge
  task automatic load(input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] i2, input logic [31:0] i3);
    reset = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 256; i++) dut.MEM[i] = NOP;
    dut.MEM[0] = i0;
    dut.MEM[1] = i1;
    dut.MEM[2] = i2;
    dut.MEM[3] = i3;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Programs: mostly x2/x3 setup, one operation into x1
    vecs.push_back('{"add",  addi(X2,12'd5),    addi(X3,12'd7),  r_t(7'h00,X3,X2,3'b000,X1), NOP, 6, 32'd12});
    vecs.push_back('{"sub",  addi(X2,12'd5),    addi(X3,12'd7),  r_t(7'h20,X3,X2,3'b000,X1), NOP, 6, 32'hFFFF_FFFE});
    vecs.push_back('{"sll",  addi(X2,12'd3),    addi(X3,12'd36), r_t(7'h00,X3,X2,3'b001,X1), NOP, 6, 32'd48});
    vecs.push_back('{"slt",  addi(X2,12'hFFF),  addi(X3,12'd1),  r_t(7'h00,X3,X2,3'b010,X1), NOP, 6, 32'd1});
    vecs.push_back('{"sltu", addi(X2,12'hFFF),  addi(X3,12'd1),  r_t(7'h00,X3,X2,3'b011,X1), NOP, 6, 32'd0});
    vecs.push_back('{"xor",  addi(X2,12'h0F0),  addi(X3,12'h0FF),r_t(7'h00,X3,X2,3'b100,X1), NOP, 6, 32'h0000_000F});
    vecs.push_back('{"srl",  addi(X2,12'hFF0),  addi(X3,12'd4),  r_t(7'h00,X3,X2,3'b101,X1), NOP, 6, 32'h0FFF_FFFF});
    vecs.push_back('{"sra",  addi(X2,12'hFF0),  addi(X3,12'd4),  r_t(7'h20,X3,X2,3'b101,X1), NOP, 6, 32'hFFFF_FFFF});
    vecs.push_back('{"or",   addi(X2,12'h0F0),  addi(X3,12'h00F),r_t(7'h00,X3,X2,3'b110,X1), NOP, 6, 32'h0000_00FF});
    vecs.push_back('{"and",  addi(X2,12'h0F0),  addi(X3,12'h03C),r_t(7'h00,X3,X2,3'b111,X1), NOP, 6, 32'h0000_0030});
    vecs.push_back('{"add_wrap", u_t(20'h80001,X2,7'b0110111), u_t(20'h80000,X3,7'b0110111),
                     r_t(7'h00,X3,X2,3'b000,X1), NOP, 6, 32'h0000_1000});
    vecs.push_back('{"srai", addi(X2,12'hF00),  NOP, i_t(12'h404,X2,3'b101,X1,OPI), NOP, 6, 32'hFFFF_FFF0});
    vecs.push_back('{"srli", addi(X2,12'hF00),  NOP, i_t(12'h004,X2,3'b101,X1,OPI), NOP, 6, 32'h0FFF_FFF0});
    vecs.push_back('{"slli", addi(X2,12'd1),    NOP, i_t(12'h01F,X2,3'b001,X1,OPI), NOP, 6, 32'h8000_0000});
    vecs.push_back('{"slti", addi(X2,12'hFFE),  NOP, i_t(12'hFFF,X2,3'b010,X1,OPI), NOP, 6, 32'd1});
    vecs.push_back('{"sltiu",addi(X2,12'd5),    NOP, i_t(12'hFFF,X2,3'b011,X1,OPI), NOP, 6, 32'd1});
    vecs.push_back('{"xori", addi(X2,12'd5),    NOP, i_t(12'hFFF,X2,3'b100,X1,OPI), NOP, 6, 32'hFFFF_FFFA});
    vecs.push_back('{"auipc",NOP, NOP, u_t(20'h00001,X1,7'b0010111), NOP, 6, 32'h0000_1008});
    vecs.push_back('{"load_store_ecall_nop", addi(X1,12'd5), i_t(12'h000,X0,3'b010,X1,7'b0000011),
                     i_t(12'h000,X0,3'b010,X1,7'b0100011), 32'h0000_0073, 8, 32'd5});
    vecs.push_back('{"jalr", addi(X2,12'd13), i_t(12'h000,X2,3'b000,X1,7'b1100111),
                     addi(X1,12'd99), i_t(12'd100,X1,3'b000,X1,OPI), 6, 32'd108});
    // Branch at PC 4 skips to PC 12 when taken: taken -> x1=2, not taken -> x1=1
    vecs.push_back('{"beq_t",  addi(X2,12'd0),   b_t(13'd8,X0,X2,3'b000), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd2});
    vecs.push_back('{"beq_nt", addi(X2,12'd1),   b_t(13'd8,X0,X2,3'b000), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd1});
    vecs.push_back('{"bne_t",  addi(X2,12'd1),   b_t(13'd8,X0,X2,3'b001), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd2});
    vecs.push_back('{"blt_t",  addi(X2,12'hFFF), b_t(13'd8,X0,X2,3'b100), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd2});
    vecs.push_back('{"bge_nt", addi(X2,12'hFFF), b_t(13'd8,X0,X2,3'b101), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd1});
    vecs.push_back('{"bltu_nt",addi(X2,12'hFFF), b_t(13'd8,X0,X2,3'b110), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd1});
    vecs.push_back('{"bgeu_t", addi(X2,12'hFFF), b_t(13'd8,X0,X2,3'b111), addi(X1,12'd1), i_t(12'd2,X1,3'b000,X1,OPI), 6, 32'd2});

    // Reset state
    load(addi(X1,12'd1), NOP, NOP, NOP);
    reset = 1'b0;
    run(3);
    chk("reset_x1", x1, 32'd0);
    chk("reset_pc", dut.pc, 32'd0);
    chk("reset_ir", dut.ir, NOP);

    foreach (vecs[k]) begin
      load(vecs[k].i0, vecs[k].i1, vecs[k].i2, vecs[k].i3);
      run(vecs[k].cyc);
      chk(vecs[k].name, x1, vecs[k].exp);
    end

    // add x1,x1,x2 with all-zero registers keeps x1 at zero every cycle
    load(32'h002080B3, 32'h002080B3, 32'h002080B3, NOP);
    for (int c = 1; c <= 6; c++) begin
      run(1);
      chk($sformatf("add_zero_c%0d", c), x1, 32'd0);
    end

    // Accumulate: x1 = 3, 6, 9 at cycles 4, 6, 8
    load(addi(X2,12'd3), 32'h002080B3, 32'h002080B3, 32'h002080B3);
    run(4); chk("acc_c4", x1, 32'd3);
    run(2); chk("acc_c6", x1, 32'd6);
    run(2); chk("acc_c8", x1, 32'd9);

    // LUI then ADDI -1
    load(32'h123450B7, 32'hFFF08093, NOP, NOP);
    run(1); chk("lui_c1", x1, 32'd0);
    run(1); chk("lui_c2", x1, 32'h1234_5000);
    run(2); chk("addi_c4", x1, 32'h1234_4FFF);

    // bne loop never reaches EBREAK
    load(32'h00100093, b_t(13'h1FFC,X0,X1,3'b001), 32'h00100073, NOP);
    run(20);
    chk("loop_x1", x1, 32'd1);
    chk("loop_not_halted", {31'd0, dut.state == ST_HALT}, 32'd0);

    // beq falls through to EBREAK and freezes
    load(32'h00100093, b_t(13'h1FFC,X0,X1,3'b000), 32'h00100073, addi(X1,12'd55));
    run(6);
    chk("halt_state", {31'd0, dut.state == ST_HALT}, 32'd1);
    for (int c = 1; c <= 10; c++) begin
      run(1);
      chk($sformatf("halt_pc_c%0d", c), dut.pc, 32'd8);
      chk($sformatf("halt_x1_c%0d", c), x1, 32'd1);
    end

    // Reset during EXECUTE aborts the write, then the program restarts
    load(32'h00700093, NOP, NOP, NOP);
    run(1);
    reset = 1'b0;
    #1;
    chk("abort_x1_now", x1, 32'd0);
    run(2);
    chk("abort_x1_held", x1, 32'd0);
    chk("abort_pc_held", dut.pc, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    run(1); chk("restart_c1", x1, 32'd0);
    run(1); chk("restart_c2", x1, 32'd7);

    // jal x1,8 skips MEM[1]; x0 write is discarded so add x1,x0,x0 yields 0
    load(32'h008000EF, addi(X1,12'd99), addi(X0,12'd5), r_t(7'h00,X0,X0,3'b000,X1));
    run(2);
    chk("jal_x1", x1, 32'd4);
    chk("jal_pc", dut.pc, 32'd8);
    run(2);
    chk("jal_skip", x1, 32'd4);
    run(2);
    chk("x0_zero", x1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, number of 32-bit words in the internal unified instruction memory (power of two).
REQ-002 SHALL provide parameter RESET_PC, default 0, byte address fetched first after reset.
REQ-003 SHALL provide port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port x1, output, 32 bits: live value of architectural register x1.
REQ-006 SHALL expose the memory as a word array named MEM [0:MEM_WORDS-1] so benches and the parent can preload it hierarchically; there is no external memory port.

Function
REQ-007 SHALL execute the RV32I subset: OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND), OP-IMM (same set minus SUB, with SRAI selected by funct7 bit 5), LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, EBREAK.
REQ-008 SHALL treat LOAD, STORE, FENCE, ECALL and any unknown opcode as a NOP (PC+4, no register write).
REQ-009 SHALL use a three-state FSM: FETCH (latch MEM[PC word index] into the instruction register), EXECUTE (read rs1/rs2, compute, write rd, update PC, return to FETCH), HALT.
REQ-010 SHALL take exactly 2 clock cycles per instruction; rd and PC update on the rising edge that ends EXECUTE.
REQ-011 SHALL enter HALT on EBREAK and remain there with PC and registers frozen until reset.
REQ-012 SHALL index MEM with PC[log2(MEM_WORDS)+1:2], ignoring PC[1:0]; higher PC bits are ignored so fetch wraps modulo memory size.
REQ-013 SHALL hold x0 at zero; writes with rd=0 are discarded.
REQ-014 SHALL use rs2[4:0] or imm[4:0] as the shift amount; SRA/SRAI sign-extend.
REQ-015 SHALL perform all arithmetic modulo 2^32 with no overflow trap; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-016 SHALL write PC+4 to rd for JAL/JALR; JALR target = (rs1+imm) with bit 0 cleared; JAL/branch target = PC+imm.
REQ-017 SHALL read source operands before the write of the same instruction (e.g. add x1,x1,x2 uses the old x1).
REQ-018 SHALL drive x1 combinationally from the register file (no extra latency).

Reset
REQ-019 SHALL, while reset is low, force PC=RESET_PC, state=FETCH, instruction register=32'h00000013 (NOP), and all 31 registers to zero, so x1 reads 0.
REQ-020 SHALL abort any in-flight instruction when reset is asserted mid-operation; no partial register write may occur.
REQ-021 SHALL NOT clear or modify MEM on reset.
REQ-022 SHALL begin fetching on the first rising CLK edge after reset deasserts.

Structure
REQ-023 SHALL place opcode constants (7-bit major opcodes), funct3 codes and the FSM state encoding in a shared package processor_pkg.
REQ-024 SHALL implement the register file as one sub-module processor_regfile (2 async read ports, 1 sync write port, async reset, x0 hardwired zero).
REQ-025 SHALL keep decode, immediate generation, ALU and branch comparison inside processor.

Verification
REQ-026 Preload MEM[0..2]=add x1,x1,x2 (32'h002080B3), release reset, run 6 cycles -> x1 stays 0 throughout.
REQ-027 MEM[0]=addi x2,x0,3; MEM[1..3]=add x1,x1,x2 -> x1 = 3, 6, 9 at the ends of cycles 4, 6, 8 after reset release.
REQ-028 MEM[0]=lui x1,0x12345; MEM[1]=addi x1,x1,-1 -> x1=32'h12345000 after cycle 2, 32'h12344FFF after cycle 4.
REQ-029 MEM[0]=addi x1,x0,1; MEM[1]=bne x1,x0,-4 loop with MEM[2]=ebreak unreachable; then replace with beq x1,x0 -> falls through to EBREAK, PC frozen, x1=1 for 10 further cycles.
REQ-030 Assert reset during EXECUTE of addi x1,x0,7 -> x1 remains 0; after release program restarts and x1=7 at cycle 2.
REQ-031 MEM[0]=jal x1,8 -> x1=4, next fetch from MEM[2]; addi x0,x0,5 anywhere -> x0 still reads 0.
